// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared types, codes and helpers for the Tuse/Tnew hazard scoreboard
package hazard_scoreboard_pkg;
    localparam logic [2:0] TUSE_NONE = 3'd5;
    localparam int TNEW_W = 2;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E = 2'd1;
    localparam logic [1:0] FWD_M = 2'd2;
    localparam logic [1:0] FWD_W = 2'd3;
    localparam logic [1:0] FWD_PIPE = 2'd0;
    localparam logic [1:0] FWD_E_M = 2'd1;
    localparam logic [1:0] FWD_E_W = 2'd2;
    localparam logic [1:0] FWD_M_W = 2'd2;

    typedef logic [TNEW_W-1:0] tnew_t;

    typedef struct packed {
        logic [4:0] dst;
        tnew_t      tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stageEntry_t;

    localparam stageEntry_t BUBBLE = '0;

    function automatic tnew_t ageTnew(tnew_t t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side operand/Tuse/Tnew info in, stall and forward selects out
interface hazard_scoreboard_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [2:0] d_tuse_rs;
    logic [2:0] d_tuse_rt;
    logic [4:0] d_regdst;
    logic [1:0] d_tnew;
    logic       d_is_md;
    logic       md_busy;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic [1:0] fwd_m_rt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regdst, d_tnew, d_is_md, md_busy, flush,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regdst, d_tnew, d_is_md, md_busy, flush,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
    );
endinterface

// File: rtl/hazard_scoreboard_stage_reg.sv
// hazard_stage_reg: one pipeline stage of {dst,tnew,rs,rt} with saturating Tnew ageing and clear
module hazard_stage_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  stageEntry_t din,
    output stageEntry_t q
);
    always_ff @(posedge clk) begin
        if (reset || clear) q <= BUBBLE;
        else q <= '{dst: din.dst, tnew: ageTnew(din.tnew), rs: din.rs, rt: din.rt};
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and D/E/M forwarding selects from E/M/W destination tracking
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hz
);
    stageEntry_t eIn, eQ, mQ, wQ;
    logic stallRs, stallRt, stallMd, stallAny;
    logic unusedBits;

    function automatic logic hit(logic [4:0] dst, logic [4:0] r);
        return dst == r && r != 5'd0;
    endfunction

    function automatic logic needStall(logic [4:0] r, logic [2:0] tuse, stageEntry_t e, stageEntry_t m);
        tnew_t near = hit(e.dst, r) ? e.tnew : m.tnew;
        return tuse != TUSE_NONE && (hit(e.dst, r) || hit(m.dst, r)) && {1'b0, near} > tuse;
    endfunction

    // An older match behind a not-yet-ready nearer one is stale, so it is never chosen.
    function automatic logic [1:0] dFwd(logic [4:0] r, stageEntry_t e, stageEntry_t m, stageEntry_t w);
        return hit(e.dst, r) ? (e.tnew == '0 ? FWD_E : FWD_RF) :
               hit(m.dst, r) ? (m.tnew == '0 ? FWD_M : FWD_RF) :
               (hit(w.dst, r) && w.tnew == '0) ? FWD_W : FWD_RF;
    endfunction

    function automatic logic [1:0] eFwd(logic [4:0] r, stageEntry_t m, stageEntry_t w);
        return hit(m.dst, r) ? (m.tnew == '0 ? FWD_E_M : FWD_PIPE) :
               hit(w.dst, r) ? FWD_E_W : FWD_PIPE;
    endfunction

    assign stallRs = needStall(hz.d_rs, hz.d_tuse_rs, eQ, mQ);
    assign stallRt = needStall(hz.d_rt, hz.d_tuse_rt, eQ, mQ);
    assign stallMd = hz.d_is_md && hz.md_busy;
    assign stallAny = stallRs || stallRt || stallMd;
    assign hz.stall = stallAny && !hz.flush;
    assign hz.fwd_d_rs = dFwd(hz.d_rs, eQ, mQ, wQ);
    assign hz.fwd_d_rt = dFwd(hz.d_rt, eQ, mQ, wQ);
    assign hz.fwd_e_rs = eFwd(eQ.rs, mQ, wQ);
    assign hz.fwd_e_rt = eFwd(eQ.rt, mQ, wQ);
    assign hz.fwd_m_rt = hit(wQ.dst, mQ.rt) ? FWD_M_W : FWD_PIPE;
    assign eIn = stallAny ? BUBBLE : '{dst: hz.d_regdst, tnew: hz.d_tnew, rs: hz.d_rs, rt: hz.d_rt};
    assign unusedBits = ^{mQ.rs, wQ.rs, wQ.rt};

    // W is never cleared by flush: the M instruction has already committed its write.
    hazard_stage_reg eStage (.clk(clk), .reset(reset), .clear(hz.flush), .din(eIn), .q(eQ));
    hazard_stage_reg mStage (.clk(clk), .reset(reset), .clear(hz.flush), .din(eQ), .q(mQ));
    hazard_stage_reg wStage (.clk(clk), .reset(reset), .clear(1'b0), .din(mQ), .q(wQ));
endmodule
